// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the FIFO-fed UART transmitter: FSM state encoding,
//   idle line level, default parameter values and a counter-width helper.
//   No ports.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        POP   = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    localparam logic IDLE_LEVEL       = 1'b1;
    localparam int   DEF_WIDTH        = 8;
    localparam int   DEF_CLKS_PER_BIT = 16;
    localparam int   DEF_STOP_BITS    = 1;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int BAUD_CNT_W = cnt_w(DEF_CLKS_PER_BIT);
    localparam int BIT_CNT_W  = cnt_w(DEF_WIDTH + 1);

endpackage

// File: rtl/fifo_uart_tx_baud_tick.sv
// baud_tick
//   Bit-period timer. Counts 0..clks_per_bit-1 and pulses tick during the
//   terminal count, then wraps. A synchronous restart forces the count back
//   to zero so every FSM state starts with a full bit period.
// Ports
//   clk      in  1  rising-edge clock
//   rst      in  1  asynchronous active-high reset
//   restart  in  1  synchronous clear of the count
//   tick     out 1  high in the last cycle of each bit period
module baud_tick
    import uart_pkg::*;
#(
    parameter int clks_per_bit = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int               CNT_W = cnt_w(clks_per_bit);
    localparam logic [CNT_W-1:0] TC    = CNT_W'(clks_per_bit - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx
//   Pops bytes from a synchronous FIFO and serialises each one as a UART
//   frame (start bit, width data bits LSB first, stop_bits stop bits).
//   Each frame is preceded by two idle-high cycles (POP, LOAD), including
//   back-to-back frames.
// Ports
//   clk         in  1      rising-edge clock
//   rst         in  1      asynchronous active-high reset
//   enable      in  1      permits starting new frames
//   fifo_empty  in  1      FIFO empty flag
//   fifo_data   in  width  FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out 1      single-cycle pop strobe
//   tx          out 1      registered serial line, idle high
//   busy        out 1      high from pop until the end of the last stop bit
//   frame_done  out 1      pulse in the last cycle of the last stop bit
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int width        = DEF_WIDTH,
    parameter int clks_per_bit = DEF_CLKS_PER_BIT,
    parameter int stop_bits    = DEF_STOP_BITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             tx,
    output logic             busy,
    output logic             frame_done
);

    localparam int               BIT_W     = cnt_w(width + 1);
    localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(width - 1);
    localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(stop_bits - 1);

    state_t             state_q, state_d;
    logic [width-1:0]   shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               tx_q, tx_d;
    logic               tick;
    logic               restart;

    // Any state change restarts the bit-period timer.
    assign restart = (state_d != state_q);

    baud_tick #(
        .clks_per_bit(clks_per_bit)
    ) u_baud (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            tx_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_d      = bit_q;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = fifo_data;
                state_d = START;
            end
            START: begin
                if (tick) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == LAST_DATA) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_q == LAST_STOP) begin
                        frame_done = 1'b1;
                        bit_d      = '0;
                        state_d    = (enable && !fifo_empty) ? POP : IDLE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // tx is computed from the next state so the registered line lines up
    // with the state it belongs to.
    always_comb begin
        tx_d = IDLE_LEVEL;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = IDLE_LEVEL;
        endcase
    end

    assign tx         = tx_q;
    assign fifo_rd_en = (state_q == POP);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic enable = 1'b0;

    always #5 clk = ~clk;

    // DUT A: 4 clks/bit, 1 stop bit.  DUT B: 16 clks/bit, 2 stop bits.
    logic [7:0] mem_a [16];
    logic [7:0] mem_b [16];
    logic [3:0] head_a = '0, tail_a = '0, head_b = '0, tail_b = '0;
    logic [7:0] data_a = '0, data_b = '0;
    logic       empty_a, empty_b;
    logic       rd_a, tx_a, busy_a, fd_a;
    logic       rd_b, tx_b, busy_b, fd_b;

    assign empty_a = (head_a == tail_a);
    assign empty_b = (head_b == tail_b);

    fifo_uart_tx #(.width(8), .clks_per_bit(4), .stop_bits(1)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty_a),
        .fifo_data(data_a), .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a),
        .frame_done(fd_a)
    );

    fifo_uart_tx #(.width(8), .clks_per_bit(16), .stop_bits(2)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(empty_b),
        .fifo_data(data_b), .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b),
        .frame_done(fd_b)
    );

    // FIFO models: read data registered one cycle after the pop strobe.
    int rd_cnt_a = 0, rd_cnt_b = 0, viol = 0;
    always @(posedge clk) begin
        if (rd_a) begin
            rd_cnt_a <= rd_cnt_a + 1;
            if (empty_a) viol <= viol + 1;
            else begin
                data_a <= mem_a[head_a];
                head_a <= head_a + 4'd1;
            end
        end
        if (rd_b) begin
            rd_cnt_b <= rd_cnt_b + 1;
            if (empty_b) viol <= viol + 1;
            else begin
                data_b <= mem_b[head_b];
                head_b <= head_b + 4'd1;
            end
        end
    end

    task automatic push_a(input logic [7:0] d);
        mem_a[tail_a] = d;
        tail_a = tail_a + 4'd1;
    endtask

    task automatic push_b(input logic [7:0] d);
        mem_b[tail_b] = d;
        tail_b = tail_b + 4'd1;
    endtask

    logic sel = 1'b0;
    logic tx_s, busy_s, fd_s;
    always_comb begin
        tx_s   = sel ? tx_b   : tx_a;
        busy_s = sel ? busy_b : busy_a;
        fd_s   = sel ? fd_b   : fd_a;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame symbols in time order: bit i of frame = i-th symbol on the line.
    typedef struct {
        logic [7:0]  data;
        logic [11:0] frame;
        int          nsym;
    } vec_t;

    vec_t vecs[7];

    // Waits for the start bit, then samples each symbol mid-bit and checks
    // frame_done position and busy across the whole frame. Returns on the
    // cycle after frame_done, plus the number of idle-high cycles seen first.
    task automatic check_frame(input string name, input logic [11:0] exp,
                               input int nsym, input int cpb, output int gap);
        logic [11:0] got;
        int fd_at, fd_n, busy_bad, n;
        got = '0; fd_at = -1; fd_n = 0; busy_bad = 0; gap = 0;
        n = nsym * cpb;
        while (tx_s !== 1'b0 && gap < 400) begin
            gap++;
            @(negedge clk);
        end
        if (tx_s !== 1'b0) begin
            chk({name, "_start_timeout"}, 0, 1);
            return;
        end
        for (int c = 0; c < n; c++) begin
            if (c % cpb == cpb / 2) got[c / cpb] = tx_s;
            if (fd_s === 1'b1) begin fd_n++; fd_at = c; end
            if (busy_s !== 1'b1) busy_bad++;
            @(negedge clk);
        end
        chk({name, "_bits"}, int'(got), int'(exp));
        chk({name, "_done_at"}, fd_at, n - 1);
        chk({name, "_done_cnt"}, fd_n, 1);
        chk({name, "_busy"}, busy_bad, 0);
    endtask

    int gap, hi, rd0;

    initial begin
        vecs[0] = '{8'hA5, 12'h34A, 10};
        vecs[1] = '{8'h00, 12'h200, 10};
        vecs[2] = '{8'hFF, 12'h3FE, 10};
        vecs[3] = '{8'h3C, 12'h278, 10};
        vecs[4] = '{8'h55, 12'h2AA, 10};
        vecs[5] = '{8'h0F, 12'h21E, 10};
        vecs[6] = '{8'h81, 12'h702, 11};

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_tx", int'(tx_a), 1);
        chk("rst_rd_en", int'(rd_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(fd_a), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Enabled with an empty FIFO: no pops, line idle
        enable = 1'b1;
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_a === 1'b1) hi++;
        end
        chk("empty_rd_en", rd_cnt_a, 0);
        chk("empty_tx_high", hi, 100);

        // Single byte
        push_a(vecs[0].data);
        check_frame("a5", vecs[0].frame, vecs[0].nsym, 4, gap);
        chk("a5_busy_after", int'(busy_a), 0);
        chk("a5_rd_cnt", rd_cnt_a, 1);

        // Three queued bytes back to back
        for (int i = 1; i <= 3; i++) push_a(vecs[i].data);
        for (int i = 1; i <= 3; i++) begin
            check_frame($sformatf("burst%0d", i), vecs[i].frame, vecs[i].nsym, 4, gap);
            if (i > 1) chk($sformatf("burst%0d_gap", i), gap, 2);
        end
        chk("burst_rd_cnt", rd_cnt_a, 4);

        // Enable dropped during the first of two queued frames
        enable = 1'b0;
        @(negedge clk);
        push_a(vecs[4].data);
        push_a(vecs[5].data);
        enable = 1'b1;
        hi = 0;
        while (busy_a !== 1'b1 && hi < 50) begin hi++; @(negedge clk); end
        chk("en_busy_seen", int'(busy_a), 1);
        enable = 1'b0;
        check_frame("en_f1", vecs[4].frame, vecs[4].nsym, 4, gap);
        rd0 = rd_cnt_a;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            if (tx_a === 1'b1 && busy_a === 1'b0) hi++;
            @(negedge clk);
        end
        chk("en_hold_idle", hi, 50);
        chk("en_hold_rd_cnt", rd0, 5);
        chk("en_hold_rd_cnt_after", rd_cnt_a, 5);
        enable = 1'b1;
        check_frame("en_f2", vecs[5].frame, vecs[5].nsym, 4, gap);
        chk("en_rd_cnt", rd_cnt_a, 6);

        // Reset in the middle of the data bits
        push_a(8'hC3);
        hi = 0;
        while (tx_a !== 1'b0 && hi < 50) begin hi++; @(negedge clk); end
        chk("rstmid_started", int'(tx_a), 0);
        repeat (12) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_tx", int'(tx_a), 1);
        chk("rstmid_rd_en", int'(rd_a), 0);
        chk("rstmid_busy", int'(busy_a), 0);
        @(negedge clk);
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx_a === 1'b1 && busy_a === 1'b0) hi++;
        end
        chk("rstmid_stays_idle", hi, 60);
        chk("rstmid_rd_cnt", rd_cnt_a, 7);

        // Two stop bits, 16 clks per bit
        sel = 1'b1;
        push_b(vecs[6].data);
        check_frame("b81", vecs[6].frame, vecs[6].nsym, 16, gap);
        chk("b81_busy_after", int'(busy_b), 0);
        chk("b81_rd_cnt", rd_cnt_b, 1);

        chk("rd_en_while_empty", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
